chunked_adder_nbits: RTL and testbench
======================================

# chunked_adder_nbits

Parametrised multi-cycle adder/subtractor, the sequential successor to the 4-bit ripple full adder. It adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, and chains the carry between cycles in a register. A start/busy/done handshake frames each operation, and an add/subtract mode and a signed-overflow flag are included. It sits in datapaths where a full-width combinational carry chain would not close timing.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only while idle.
- sub  input  1  0 = a + b + c_in, 1 = a − b − c_in; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry-in (add) / borrow-in (sub); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; held between operations.
- c_out  output  1  raw carry out of MSB (in sub mode 1 = no borrow).
- ovf  output  1  two's-complement overflow of the result.

## Operation
- States: IDLE, RUN. There is no separate DONE state; done is a registered pulse.
- Start capture: in IDLE with start=1, the block captures the following and enters RUN, sets busy=1, and sets idx=0.
  - opA = a
  - opB = sub ? ~b : b
  - carry = sub ? ~c_in : c_in
- RUN, each cycle:
  - {carry, chunk} = opA[idx] + opB[idx] + carry, all CHUNK-bit slices with idx 0 = LSBs.
  - The chunk is written into an internal result register, and idx increments.
- Last chunk (idx = N−1), on the same edge:
  - sum ← completed result.
  - c_out ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB, computed on opB as actually added (the inverted b in sub mode).
  - busy ← 0, done ← 1, state ← IDLE.
- done clears on the next edge unless that edge also ends another operation, which is impossible for N ≥ 2.
- sum, c_out and ovf change only on the last-chunk edge. They hold their values through RUN and IDLE.
- start while busy=1 is ignored, with no queuing. a, b, sub and c_in may change freely during RUN.
- start asserted in the cycle where done=1 is legal, since the state is IDLE. The new operation is captured, and done still drops on that edge.
- Arithmetic is modulo 2^WIDTH. In sub mode the result is a + ~b + ~c_in = a − b − c_in.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, c_out=0, ovf=0. Reset dominates start.
- Reset during RUN aborts the operation: no done pulse, and all outputs take their reset values.
- Cycle-level sequence, with E0 as the edge that samples start:
  - busy is high after E0.
  - Chunks are processed at edges E1..EN.
  - sum, c_out and ovf are valid, and done is high, in the cycle after EN.
  - Latency is N edges from start capture to done.
- Case N=1 (CHUNK=WIDTH): done follows start by one edge. busy is high for exactly one cycle.
- Throughput: one operation per N+1 cycles with idle gaps, or one per N+1 edges when start is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16 and CHUNK=4, so N=4.
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0x0000, c_out=0, ovf=0. No operation starts.
- Basic add: a=0x0003, b=0x0004, c_in=0, sub=0 -> done exactly 4 edges after start; sum=0x0007, c_out=0, ovf=0; busy high for 4 cycles.
- Carry chain:
  - a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
  - a=0x1234, b=0x0FFF, c_in=1 -> sum=0x2234, c_out=0.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1.
  - a=0x0009, b=0x0002, sub=1, c_in=1 -> sum=0x0006, c_out=1.
- Handshake:
  - Pulse start again 2 cycles into RUN with different operands -> ignored; the first result is returned.
  - sum holds its previous value throughout RUN.
  - start asserted in the done cycle -> the second operation completes 4 edges later with a correct result.
- Reset mid-op: drop rst_n at RUN edge E2 -> no done pulse, outputs zero. A fresh start after reset gives a correct result.

Source files
------------

// File: rtl/chunked_adder_nbits.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock,
// LSB chunk first, chaining the carry between cycles through a register.
module chunked_adder_nbits #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  int unsigned      base;
  logic [CHUNK-1:0] a_sl, b_sl, chunk;
  logic             chunk_c;
  logic             msb_cin;
  logic             last;

  // One chunk of the ripple: slice select, add, and carry into the chunk MSB.
  always_comb begin
    base    = 32'(idx_q) * CHUNK;
    a_sl    = opa_q[base +: CHUNK];
    b_sl    = opb_q[base +: CHUNK];
    {chunk_c, chunk} = (CHUNK+1)'(a_sl) + (CHUNK+1)'(b_sl) + (CHUNK+1)'(carry_q);
    msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ chunk[CHUNK-1];
    last    = (idx_q == IDX_W'(N - 1));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? ~c_in : c_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[base +: CHUNK] = chunk;
        carry_d = chunk_c;
        idx_d   = idx_q + IDX_W'(1);
        if (last) begin
          sum_d   = res_d;
          c_out_d = chunk_c;
          ovf_d   = msb_cin ^ chunk_c;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_adder_nbits.sv
// Directed bench for chunked_adder_nbits (WIDTH=16, CHUNK=4): hand-computed vectors,
// handshake corner cases and mid-operation reset.
module tb_chunked_adder_nbits;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  int total;
  int bad;

  chunked_adder_nbits #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from the current cycle and wait for done; returns in the done cycle.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin,
                        input logic [15:0] esum, input logic ec, input logic eo);
    int          n;
    int          busy_cnt;
    logic        held;
    logic [15:0] prev;
    a = ia; b = ib; sub = isub; c_in = icin; start = 1'b1;
    prev = sum;
    tick();
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~isub; c_in = ~icin;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    n = 0; busy_cnt = 0; held = 1'b1;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (sum !== prev) held = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    chk({tag, "_sum_held"}, 32'(held), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h4321; c_in = 1'b1;

    // Reset with start held high.
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    run_op("add_basic", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    tick();
    chk("done_pulse_clear", 32'(done), 32'd0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick(); tick();
    run_op("add_cin", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0);
    tick();
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    tick();
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    tick();
    run_op("sub_bin", 16'h0009, 16'h0002, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);

    // Back-to-back: start asserted in the done cycle.
    run_op("b2b", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    tick();

    // Start pulsed two cycles into RUN must be ignored.
    a = 16'h0003; b = 16'h0004; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 16'h1111; b = 16'h2222; sub = 1'b1; c_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("ign_latency", 32'(n), 32'd1);
    chk("ign_sum", 32'(sum), 32'h0007);
    tick();
    chk("ign_no_second", 32'(busy), 32'd0);

    // Leave nonzero flags, then reset at RUN edge E2.
    run_op("pre_rst", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    tick();
    a = 16'h0001; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_c_out", 32'(c_out), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end
    run_op("after_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h0123, 1'b1, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
